// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the MDU issue controller.
//   e_kind_t  - E-stage MDU instruction kinds as decoded upstream
//   mdu_op_t  - operation code presented to the MDU with Start
//   state_t   - issue controller FSM states
//   *_LAT_DEF - default Busy latencies of the MDU in cycles
package mdu_pkg;

  typedef enum logic [2:0] {
    KMulu = 3'd0,
    KMul  = 3'd1,
    KDivu = 3'd2,
    KDiv  = 3'd3,
    KMthi = 3'd4,
    KMtlo = 3'd5,
    KMfhi = 3'd6,
    KMflo = 3'd7
  } e_kind_t;

  typedef enum logic [1:0] {
    OpMulu = 2'd0,
    OpMul  = 2'd1,
    OpDivu = 2'd2,
    OpDiv  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StErrHold = 2'd2
  } state_t;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;
  localparam int unsigned CNT_W_DEF   = 4;

  // Kinds 0-3 need the MDU datapath; kinds 4-7 only touch HI/LO.
  function automatic logic is_muldiv(input logic [2:0] kind);
    return ~kind[2];
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// mdu_issue_ctrl_if: strobe/busy handshake between the E-stage issue controller and the MDU.
//   Start    - start a multiply/divide (one cycle)
//   MDUOp    - operation code, valid with Start
//   HIWrite  - mthi write strobe
//   LOWrite  - mtlo write strobe
//   MDU_Busy - MDU is computing
// master: issue controller side; slave: MDU side.
interface mdu_issue_ctrl_if;

  logic       Start;
  logic [1:0] MDUOp;
  logic       HIWrite;
  logic       LOWrite;
  logic       MDU_Busy;

  modport master (
    output Start,
    output MDUOp,
    output HIWrite,
    output LOWrite,
    input  MDU_Busy
  );

  modport slave (
    input  Start,
    input  MDUOp,
    input  HIWrite,
    input  LOWrite,
    output MDU_Busy
  );

endinterface

// File: rtl/mdu_lat_counter.sv
// mdu_lat_counter: latency down-counter for the MDU issue controller.
//   Clk, Reset_n - clock, asynchronous active-low reset
//   load         - load load_val (highest priority)
//   clr          - force count to zero
//   dec          - decrement, saturating at zero
//   cnt          - current count
//   zero         - cnt == 0
module mdu_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic             clr,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clr) begin
      cnt_d = '0;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage initiator for the multiply/divide unit.
//   Clk, Reset_n - clock, asynchronous active-low reset
//   E_Req        - E-stage instruction is an MDU instruction
//   E_Kind       - MDU instruction kind (mdu_pkg::e_kind_t)
//   Flush        - flush of E this cycle; blocks every strobe
//   mdu          - Start/MDUOp/HIWrite/LOWrite out, MDU_Busy in
//   Stall        - hold F/D/E while an MDU result is pending
//   ProtoErr     - sticky: MDU_Busy disagreed with the expected latency
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                E_Req,
  input  logic [2:0]          E_Kind,
  input  logic                Flush,
  mdu_issue_ctrl_if.master    mdu,
  output logic                Stall,
  output logic                ProtoErr
);

  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic             start_q;
  logic             stall;
  logic             issue;
  logic             issue_md;
  logic             cnt_load, cnt_clr, cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  // Outputs are gated by Reset_n so nothing strobes while the MDU is held in reset.
  assign stall    = Reset_n & E_Req & ~Flush & ((state_q != StIdle) | mdu.MDU_Busy);
  assign issue    = Reset_n & E_Req & ~Flush & ~stall;
  assign issue_md = issue & is_muldiv(E_Kind);

  assign Stall       = stall;
  assign ProtoErr    = err_q;
  assign mdu.Start   = issue_md;
  assign mdu.MDUOp   = issue_md ? E_Kind[1:0] : 2'b00;
  assign mdu.HIWrite = issue & (E_Kind == KMthi);
  assign mdu.LOWrite = issue & (E_Kind == KMtlo);

  assign cnt_load_val = E_Kind[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  mdu_lat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (cnt_load),
    .clr      (cnt_clr),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      StIdle: begin
        // Busy with no Start behind it means the MDU is running on its own or ran late.
        if (mdu.MDU_Busy && !start_q) begin
          err_d = 1'b1;
        end
        if (issue_md) begin
          cnt_load = 1'b1;
          state_d  = StRun;
        end
      end

      StRun: begin
        cnt_dec = 1'b1;
        if (!mdu.MDU_Busy) begin
          // Busy dropped before the expected latency elapsed.
          if (!cnt_zero) begin
            err_d = 1'b1;
          end
          cnt_clr = 1'b1;
          state_d = StIdle;
        end else if (cnt_zero) begin
          err_d   = 1'b1;
          state_d = StErrHold;
        end else if (cnt == CNT_W'(1)) begin
          // Last expected Busy cycle: leave now so a dependent instruction can issue
          // in the following cycle, where Busy must already be low.
          state_d = StIdle;
        end
      end

      StErrHold: begin
        if (!mdu.MDU_Busy) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      start_q <= issue_md;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  localparam int MulLat = 5;
  localparam int DivLat = 10;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       E_Req = 1'b0;
  logic [2:0] E_Kind = 3'd0;
  logic       Flush = 1'b0;
  logic       Stall;
  logic       ProtoErr;

  mdu_issue_ctrl_if bif ();

  mdu_issue_ctrl #(
    .MUL_LAT (MulLat),
    .DIV_LAT (DivLat),
    .CNT_W   (4)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .E_Req    (E_Req),
    .E_Kind   (E_Kind),
    .Flush    (Flush),
    .mdu      (bif),
    .Stall    (Stall),
    .ProtoErr (ProtoErr)
  );

  always #5 Clk = ~Clk;

  // Behavioural MDU: Busy for LAT cycles after a Start, optionally overridden.
  int   busy_cnt;
  logic ovr_en = 1'b0;
  logic ovr_val = 1'b0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) busy_cnt <= 0;
    else if (bif.Start) busy_cnt <= bif.MDUOp[1] ? DivLat : MulLat;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign bif.MDU_Busy = ovr_en ? ovr_val : (busy_cnt > 0);

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard of expected strobe cycles: {Start, MDUOp, HIWrite, LOWrite}.
  logic [4:0] sb[$];

  always @(negedge Clk) begin
    if (Reset_n && (bif.Start || bif.HIWrite || bif.LOWrite)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {27'd0, bif.Start, bif.MDUOp, bif.HIWrite, bif.LOWrite}, 32'd0);
      end else begin
        chk("sb_strobe", {27'd0, bif.Start, bif.MDUOp, bif.HIWrite, bif.LOWrite},
            {27'd0, sb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [2:0] kind, input logic fl);
    E_Req  = req;
    E_Kind = kind;
    Flush  = fl;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    drive(1'b0, 3'd0, 1'b0);
    ovr_en  = 1'b0;
    ovr_val = 1'b0;
    step();
    Reset_n = 1'b1;
  endtask

  // Called with inputs already driven; returns at the negedge of the first unstalled cycle.
  task automatic count_stall(input int bound, output int n);
    n = 0;
    forever begin
      @(negedge Clk);
      if (!Stall) break;
      n++;
      if (n > bound) begin
        chk("stall_bound", 32'(n), 32'(bound));
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic       req;
    logic [2:0] kind;
    logic       fl;
    logic       busy;
    logic [5:0] exp;   // {Stall, Start, MDUOp, HIWrite, LOWrite}
  } vec_t;

  vec_t vecs[14];

  initial begin
    int n;

    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0]  = '{1'b0, KMul,  1'b0, 1'b0, 6'b000000};
    vecs[1]  = '{1'b1, KMul,  1'b0, 1'b0, 6'b010100};
    vecs[2]  = '{1'b1, KMulu, 1'b0, 1'b0, 6'b010000};
    vecs[3]  = '{1'b1, KDivu, 1'b0, 1'b0, 6'b011000};
    vecs[4]  = '{1'b1, KDiv,  1'b0, 1'b0, 6'b011100};
    vecs[5]  = '{1'b1, KMthi, 1'b0, 1'b0, 6'b000010};
    vecs[6]  = '{1'b1, KMtlo, 1'b0, 1'b0, 6'b000001};
    vecs[7]  = '{1'b1, KMfhi, 1'b0, 1'b0, 6'b000000};
    vecs[8]  = '{1'b1, KMflo, 1'b0, 1'b0, 6'b000000};
    vecs[9]  = '{1'b1, KMulu, 1'b1, 1'b0, 6'b000000};
    vecs[10] = '{1'b1, KMthi, 1'b1, 1'b0, 6'b000000};
    vecs[11] = '{1'b1, KMul,  1'b0, 1'b1, 6'b100000};
    vecs[12] = '{1'b1, KMflo, 1'b1, 1'b1, 6'b000000};
    vecs[13] = '{1'b1, KMtlo, 1'b0, 1'b1, 6'b100000};

    // Outputs held low during reset even with a request and Busy present.
    Reset_n = 1'b0;
    drive(1'b1, KMul, 1'b0);
    ovr_en  = 1'b1;
    ovr_val = 1'b1;
    #17;
    chk("reset_outputs", {27'd0, Stall, bif.Start, bif.HIWrite, bif.LOWrite, ProtoErr}, 32'd0);

    // Single-cycle decode from IDLE, fresh reset per vector.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      drive(vecs[i].req, vecs[i].kind, vecs[i].fl);
      ovr_en  = 1'b1;
      ovr_val = vecs[i].busy;
      if (vecs[i].exp[4] || vecs[i].exp[1] || vecs[i].exp[0]) sb.push_back(vecs[i].exp[4:0]);
      @(negedge Clk);
      chk($sformatf("vec%0d", i),
          {26'd0, Stall, bif.Start, bif.MDUOp, bif.HIWrite, bif.LOWrite}, {26'd0, vecs[i].exp});
      step();
    end

    // MUL: one Start, flush during RUN, then back-to-back MUL waits out the latency.
    do_reset();
    drive(1'b1, KMul, 1'b0);
    sb.push_back(5'b1_01_00);
    @(negedge Clk);
    chk("mul_stall0", {31'd0, Stall}, 32'd0);
    step();
    drive(1'b0, KMul, 1'b0);
    @(negedge Clk);
    chk("mul_noreq_stall", {31'd0, Stall}, 32'd0);
    step();
    drive(1'b1, KMul, 1'b1);
    @(negedge Clk);
    chk("run_flush", {30'd0, Stall, bif.Start}, 32'd0);
    step();
    drive(1'b1, KMul, 1'b0);
    sb.push_back(5'b1_01_00);
    count_stall(20, n);
    chk("mul_b2b_stalls", 32'(n), 32'd3);
    step();
    drive(1'b0, 3'd0, 1'b0);
    repeat (8) step();
    chk("mul_protoerr", {31'd0, ProtoErr}, 32'd0);

    // DIVU followed by dependent MFLO.
    do_reset();
    drive(1'b1, KDivu, 1'b0);
    sb.push_back(5'b1_10_00);
    step();
    drive(1'b1, KMflo, 1'b0);
    count_stall(30, n);
    chk("divu_mflo_stalls", 32'(n), 32'd10);
    step();
    drive(1'b0, 3'd0, 1'b0);
    step();
    chk("divu_protoerr", {31'd0, ProtoErr}, 32'd0);

    // MTHI in IDLE.
    do_reset();
    drive(1'b1, KMthi, 1'b0);
    sb.push_back(5'b0_00_10);
    @(negedge Clk);
    chk("mthi_stall", {30'd0, Stall, bif.Start}, 32'd0);
    step();
    drive(1'b1, KMfhi, 1'b0);
    @(negedge Clk);
    chk("mthi_stays_idle", {31'd0, Stall}, 32'd0);
    step();
    drive(1'b0, 3'd0, 1'b0);

    // MULU flushed at issue.
    do_reset();
    drive(1'b1, KMulu, 1'b1);
    @(negedge Clk);
    chk("flush_mulu", {30'd0, Stall, bif.Start}, 32'd0);
    step();
    drive(1'b1, KMflo, 1'b0);
    @(negedge Clk);
    chk("flush_idle", {31'd0, Stall}, 32'd0);
    chk("flush_cnt", {28'd0, dut.cnt}, 32'd0);
    step();
    drive(1'b0, 3'd0, 1'b0);

    // DIV with Busy dropping after 4 cycles.
    do_reset();
    drive(1'b1, KDiv, 1'b0);
    sb.push_back(5'b1_11_00);
    step();
    drive(1'b0, 3'd0, 1'b0);
    repeat (3) step();
    @(negedge Clk);
    chk("div_err_before", {31'd0, ProtoErr}, 32'd0);
    step();
    ovr_en  = 1'b1;
    ovr_val = 1'b0;
    step();
    drive(1'b1, KMflo, 1'b0);
    @(negedge Clk);
    chk("div_early_err", {31'd0, ProtoErr}, 32'd1);
    chk("div_err_idle", {31'd0, Stall}, 32'd0);
    step();
    drive(1'b0, 3'd0, 1'b0);
    repeat (5) step();
    chk("div_err_sticky", {31'd0, ProtoErr}, 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("div_err_reset", {31'd0, ProtoErr}, 32'd0);

    // Busy in IDLE without a Start.
    do_reset();
    ovr_en  = 1'b1;
    ovr_val = 1'b1;
    step();
    ovr_val = 1'b0;
    @(negedge Clk);
    chk("idle_busy_err", {31'd0, ProtoErr}, 32'd1);

    // Asynchronous reset three cycles into RUN.
    do_reset();
    drive(1'b1, KMul, 1'b0);
    sb.push_back(5'b1_01_00);
    step();
    drive(1'b1, KMflo, 1'b0);
    step();
    step();
    @(negedge Clk);
    chk("run_stall", {31'd0, Stall}, 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset", {29'd0, Stall, bif.Start, ProtoErr}, 32'd0);
    step();
    Reset_n = 1'b1;
    drive(1'b1, KMul, 1'b0);
    sb.push_back(5'b1_01_00);
    @(negedge Clk);
    chk("post_reset_issue", {30'd0, Stall, bif.Start}, 32'd1);
    step();
    drive(1'b0, 3'd0, 1'b0);
    repeat (8) step();
    chk("post_reset_protoerr", {31'd0, ProtoErr}, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
